waveform_sequencer: RTL
=======================

WAVEFORM_SEQUENCER -- requirements
Module: waveform_sequencer

Interface
REQ-001 The block SHALL have parameter CFG_DATA_WIDTH, default 64, giving the width of the generator config word.
REQ-002 The block SHALL have parameter PINC_WIDTH, default 32, giving the width of the DDS phase increment.
REQ-003 The block SHALL have parameter DUR_WIDTH, default 32, giving the width of the step duration in clk cycles.
REQ-004 The block SHALL have parameter DEPTH_LOG2, default 4, giving the table depth as 2**DEPTH_LOG2 entries.
REQ-005 The block SHALL have port clk  input  1  clock.
REQ-006 The block SHALL have port aresetn  input  1  reset, synchronous, active-low.
REQ-007 The block SHALL have port wr_en  input  1  table write strobe.
REQ-008 The block SHALL have port wr_addr  input  DEPTH_LOG2  table write index.
REQ-009 The block SHALL have port wr_data  input  CFG_DATA_WIDTH+PINC_WIDTH+DUR_WIDTH  entry, packed {duration, pinc, cfg}, with cfg in the LSBs.
REQ-010 The block SHALL have port num_steps  input  DEPTH_LOG2+1  number of active entries, sampled on start.
REQ-011 The block SHALL have port start  input  1  single-cycle start pulse.
REQ-012 The block SHALL have port stop  input  1  single-cycle abort pulse.
REQ-013 The block SHALL have port loop_count  input  16  whole-table repetitions, 0 meaning infinite, sampled on start (SEQ_LOOP_EN only).
REQ-014 The block SHALL have port gen_cfg_data  output  CFG_DATA_WIDTH  config word to the signal generator: [3:0] type, [31:16] A, [47:32] AIncrement.
REQ-015 The block SHALL have port gen_aresetn  output  1  active-low reset to the signal generator; this reset reloads gen_cfg_data.
REQ-016 The block SHALL have port dds_pinc  output  PINC_WIDTH  phase increment to the DDS.
REQ-017 The block SHALL have port step_idx  output  DEPTH_LOG2  index of the current entry.
REQ-018 The block SHALL have port busy  output  1  high in any state other than IDLE.
REQ-019 The block SHALL have port done  output  1  one-cycle pulse when the sequence completes normally.
REQ-020 The block SHALL have port wr_err  output  1  one-cycle pulse when a write is dropped.

Function
REQ-021 The block SHALL implement the states IDLE, LOAD, RUN and DONE.
REQ-022 IDLE SHALL behave as follows:
- gen_aresetn is 0 and busy is 0.
- start with num_steps in 1..2**DEPTH_LOG2 goes to LOAD with idx=0.
- start with num_steps==0 goes to DONE.
- num_steps above the depth is clamped to the depth.
REQ-023 LOAD SHALL last exactly 1 cycle and SHALL behave as follows:
- gen_cfg_data, dds_pinc and step_idx are registered from table[idx].
- gen_aresetn is 0.
- cnt is set to duration, with duration 0 treated as 1.
- The next state is RUN.
REQ-024 RUN SHALL behave as follows:
- gen_aresetn is 1.
- cnt decrements by 1 per cycle.
- When cnt==1 and idx<num_steps-1: idx increments and the next state is LOAD.
- When cnt==1 and idx==num_steps-1: the next state is DONE, unless looping per REQ-033.
REQ-025 DONE SHALL last 1 cycle, SHALL assert done=1 and gen_aresetn=0, and SHALL then go to IDLE.
REQ-026 Each step SHALL occupy exactly 1+max(duration,1) cycles, with no idle gap between steps.
REQ-027 stop in any state SHALL force IDLE on the next cycle with no done pulse; stop together with start SHALL be resolved in favour of stop.
REQ-028 start while busy SHALL be ignored.
REQ-029 Writes SHALL behave as follows:
- Writes are accepted only while busy==0, with the table updated on the next edge.
- wr_en while busy drops the write and pulses wr_err.
REQ-030 gen_cfg_data and dds_pinc SHALL hold their last values in IDLE and DONE.
REQ-031 cnt SHALL be DUR_WIDTH bits wide, with no wrap: the maximum duration is 2**DUR_WIDTH-1.

Reset
REQ-032 When aresetn is low, the block SHALL set the state to IDLE, all outputs to 0 (gen_aresetn=0), and idx, cnt and the loop counter to 0; table contents are not reset.

Configuration
REQ-033 With SEQ_LOOP_EN defined, the block SHALL support looping as follows:
- At the last step's end, the sequence wraps to idx=0 through LOAD when loop_count==0, or while the completed passes are fewer than loop_count.
- The pass counter is 16 bits wide.
REQ-034 Without SEQ_LOOP_EN, loop_count SHALL be ignored, the table SHALL play once, and no pass counter SHALL exist.

Structure
REQ-035 Package waveform_seq_pkg SHALL hold the state enum, the entry field offsets/widths and the signal-type codes (SINE=0, TRAPEZOID=1, TRIANGLE=2, SAWTOOTH=3).
REQ-036 Sub-module waveform_seq_table SHALL implement a single-write, async-read table of depth 2**DEPTH_LOG2.

Verification
REQ-037 The bench SHALL cover a 2-step run: entries {type=0, pinc=0x01000000, dur=5} and {type=2, dur=3}, num_steps=2, start -> LOAD@1, RUN 5 cycles, LOAD, RUN 3 cycles, done pulse at cycle 11, gen_aresetn low exactly in the LOAD/DONE cycles.
REQ-038 The bench SHALL cover dur=0 for a single entry -> 1 LOAD cycle, then 1 RUN cycle, then done.
REQ-039 The bench SHALL cover stop during RUN of step 1 of 3 -> IDLE next cycle, no done, gen_aresetn=0, busy=0.
REQ-040 The bench SHALL cover wr_en during RUN -> wr_err pulse, table unchanged (verified by a replay).
REQ-041 The bench SHALL cover start with num_steps=0 -> done pulse 1 cycle after start, with no LOAD occurring.
REQ-042 With SEQ_LOOP_EN, the bench SHALL cover loop_count=3, num_steps=2 -> 6 LOADs then done; with loop_count=0, no done within 1000 cycles until stop.

Source files
------------

// File: rtl/waveform_seq_pkg.sv
// Shared definitions for the waveform sequencer: FSM states, table entry layout
// and the signal-generator config word fields.
package waveform_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } seqState_e;

    localparam int CFG_TYPE_LSB = 0;
    localparam int CFG_TYPE_W   = 4;
    localparam int CFG_A_LSB    = 16;
    localparam int CFG_A_W      = 16;
    localparam int CFG_AINC_LSB = 32;
    localparam int CFG_AINC_W   = 16;

    localparam logic [3:0] SIG_SINE      = 4'd0;
    localparam logic [3:0] SIG_TRAPEZOID = 4'd1;
    localparam logic [3:0] SIG_TRIANGLE  = 4'd2;
    localparam logic [3:0] SIG_SAWTOOTH  = 4'd3;

    // Table entries are packed {duration, pinc, cfg} with cfg in the LSBs.
    localparam int ENTRY_CFG_LSB = 0;

    function automatic int entryPincLsb(input int cfgWidth);
        return cfgWidth;
    endfunction

    function automatic int entryDurLsb(input int cfgWidth, input int pincWidth);
        return cfgWidth + pincWidth;
    endfunction

endpackage

// File: rtl/waveform_seq_table.sv
// Step table for the waveform sequencer: one write port, asynchronous read.
module waveform_seq_table #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 128
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [WIDTH-1:0]      rdata_o
);

    logic [WIDTH-1:0] mem_q [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/waveform_sequencer.sv
// Plays a table of {duration, pinc, cfg} steps into a signal generator and DDS.
// Optional whole-table looping is enabled by defining SEQ_LOOP_EN.
module waveform_sequencer
    import waveform_seq_pkg::*;
#(
    parameter int CFG_DATA_WIDTH = 64,
    parameter int PINC_WIDTH     = 32,
    parameter int DUR_WIDTH      = 32,
    parameter int DEPTH_LOG2     = 4
) (
    input  logic                                        clk,
    input  logic                                        aresetn,
    input  logic                                        wr_en,
    input  logic [DEPTH_LOG2-1:0]                       wr_addr,
    input  logic [CFG_DATA_WIDTH+PINC_WIDTH+DUR_WIDTH-1:0] wr_data,
    input  logic [DEPTH_LOG2:0]                         num_steps,
    input  logic                                        start,
    input  logic                                        stop,
    input  logic [15:0]                                 loop_count,
    output logic [CFG_DATA_WIDTH-1:0]                   gen_cfg_data,
    output logic                                        gen_aresetn,
    output logic [PINC_WIDTH-1:0]                       dds_pinc,
    output logic [DEPTH_LOG2-1:0]                       step_idx,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        wr_err
);

    localparam int ENTRY_W  = CFG_DATA_WIDTH + PINC_WIDTH + DUR_WIDTH;
    localparam int PINC_LSB = entryPincLsb(CFG_DATA_WIDTH);
    localparam int DUR_LSB  = entryDurLsb(CFG_DATA_WIDTH, PINC_WIDTH);
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(2**DEPTH_LOG2);

    seqState_e                 state_q, state_d;
    logic [DEPTH_LOG2-1:0]     idx_q, idx_d;
    logic [DUR_WIDTH-1:0]      cnt_q, cnt_d;
    logic [DEPTH_LOG2:0]       nSteps_q, nSteps_d;
    logic [CFG_DATA_WIDTH-1:0] cfgData_q, cfgData_d;
    logic [PINC_WIDTH-1:0]     pinc_q, pinc_d;
    logic [DEPTH_LOG2-1:0]     stepIdx_q, stepIdx_d;
    logic                      wrErr_q, wrErr_d;
`ifdef SEQ_LOOP_EN
    logic [15:0]               loops_q, loops_d;
    logic [15:0]               passes_q, passes_d;
`else
    logic                      unusedLoopCount;
    assign unusedLoopCount = ^loop_count;
`endif

    logic [ENTRY_W-1:0]        entry;
    logic [CFG_DATA_WIDTH-1:0] entryCfg;
    logic [PINC_WIDTH-1:0]     entryPinc;
    logic [DUR_WIDTH-1:0]      entryDur;
    logic                      tableWe;
    logic                      lastStep;

    // The table can only be rewritten while no sequence is using it.
    assign tableWe = wr_en && (state_q == ST_IDLE);

    waveform_seq_table #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .WIDTH     (ENTRY_W)
    ) uTable (
        .clk    (clk),
        .we_i   (tableWe),
        .waddr_i(wr_addr),
        .wdata_i(wr_data),
        .raddr_i(idx_q),
        .rdata_o(entry)
    );

    assign entryCfg  = entry[ENTRY_CFG_LSB +: CFG_DATA_WIDTH];
    assign entryPinc = entry[PINC_LSB +: PINC_WIDTH];
    assign entryDur  = entry[DUR_LSB +: DUR_WIDTH];
    assign lastStep  = ({1'b0, idx_q} == (nSteps_q - (DEPTH_LOG2+1)'(1)));

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            nSteps_q  <= '0;
            cfgData_q <= '0;
            pinc_q    <= '0;
            stepIdx_q <= '0;
            wrErr_q   <= 1'b0;
`ifdef SEQ_LOOP_EN
            loops_q   <= '0;
            passes_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            nSteps_q  <= nSteps_d;
            cfgData_q <= cfgData_d;
            pinc_q    <= pinc_d;
            stepIdx_q <= stepIdx_d;
            wrErr_q   <= wrErr_d;
`ifdef SEQ_LOOP_EN
            loops_q   <= loops_d;
            passes_q  <= passes_d;
`endif
        end
    end

    // A step is one LOAD cycle followed by max(duration,1) RUN cycles.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        nSteps_d  = nSteps_q;
        cfgData_d = cfgData_q;
        pinc_d    = pinc_q;
        stepIdx_d = stepIdx_q;
        wrErr_d   = wr_en && (state_q != ST_IDLE);
`ifdef SEQ_LOOP_EN
        loops_d   = loops_q;
        passes_d  = passes_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    nSteps_d = (num_steps > DEPTH_CNT) ? DEPTH_CNT : num_steps;
                    idx_d    = '0;
`ifdef SEQ_LOOP_EN
                    loops_d  = loop_count;
                    passes_d = '0;
`endif
                    state_d  = (num_steps == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                cfgData_d = entryCfg;
                pinc_d    = entryPinc;
                stepIdx_d = idx_q;
                cnt_d     = (entryDur == '0) ? DUR_WIDTH'(1) : entryDur;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                cnt_d = cnt_q - DUR_WIDTH'(1);
                if (cnt_q == DUR_WIDTH'(1)) begin
                    if (!lastStep) begin
                        idx_d   = idx_q + DEPTH_LOG2'(1);
                        state_d = ST_LOAD;
                    end else begin
`ifdef SEQ_LOOP_EN
                        if ((loops_q == '0) || (({1'b0, passes_q} + 17'd1) < {1'b0, loops_q})) begin
                            passes_d = passes_q + 16'd1;
                            idx_d    = '0;
                            state_d  = ST_LOAD;
                        end else begin
                            state_d = ST_DONE;
                        end
`else
                        state_d = ST_DONE;
`endif
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Abort overrides everything, including a simultaneous start.
        if (stop) begin
            state_d = ST_IDLE;
        end
    end

    assign gen_cfg_data = cfgData_q;
    assign dds_pinc     = pinc_q;
    assign step_idx     = stepIdx_q;
    assign gen_aresetn  = (state_q == ST_RUN);
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);
    assign wr_err       = wrErr_q;

endmodule
